// File: rtl/wb_pkg.sv
// Shared writeback definitions: widths, load funct3 / opcode constants and the
// load extension function used on the memory return path.
package wb_pkg;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int RW    = $clog2(NREGS);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Low offset bits below the access size are dropped, so misaligned offsets
  // select the naturally aligned container.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [2:0] off,
                                                  input logic [XLEN-1:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = raw[{off, 3'b000} +: 8];
    h = raw[{off[2:1], 4'b0000} +: 16];
    w = raw[{off[2], 5'b00000} +: 32];
    case (f3)
      F3_LB:   load_extend = {{(XLEN-8){b[7]}}, b};
      F3_LH:   load_extend = {{(XLEN-16){h[15]}}, h};
      F3_LW:   load_extend = {{(XLEN-32){w[31]}}, w};
      F3_LD:   load_extend = raw;
      F3_LBU:  load_extend = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  load_extend = {{(XLEN-16){1'b0}}, h};
      F3_LWU:  load_extend = {{(XLEN-32){1'b0}}, w};
      default: load_extend = '0;
    endcase
  endfunction
endpackage

// File: rtl/wb_skid_fifo.sv
// Small circular FIFO buffering ALU results ahead of the register file port.
module wb_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/writeback_unit.sv
// Register file write port producer: merges never-stalled load returns with
// buffered ALU results and tracks outstanding loads for RAW stalls in decode.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NREGS_P   = NREGS,
  parameter int ALU_DEPTH = 2,
  localparam int CW = $clog2(ALU_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_alu_valid,
  output logic               o_alu_ready,
  input  logic [RW-1:0]      i_alu_rd,
  input  logic [XLEN_P-1:0]  i_alu_data,
  input  logic               i_ld_issue,
  input  logic [RW-1:0]      i_ld_issue_rd,
  input  logic               i_ld_valid,
  input  logic [RW-1:0]      i_ld_rd,
  input  logic [2:0]         i_ld_funct3,
  input  logic [2:0]         i_ld_offset,
  input  logic [XLEN_P-1:0]  i_ld_raw,
  output logic               o_wr_en,
  output logic [RW-1:0]      o_destn_reg,
  output logic [XLEN_P-1:0]  o_destn_data,
  output logic [NREGS_P-1:0] o_busy_mask
);
  wb_req_t            w_head;
  wb_req_t            w_alu_req;
  logic               w_full, w_empty, w_push, w_pop, w_ld_we;
  logic [CW-1:0]      w_count;
  logic [NREGS_P-1:0] w_set, w_clr;

  logic               r_wr_en;
  logic [RW-1:0]      r_reg;
  logic [XLEN_P-1:0]  r_data;
  logic [NREGS_P-1:0] r_busy;

  // Readiness is from registered count only; no credit for a same-cycle pop.
  assign o_alu_ready = !reset && (w_count < CW'(ALU_DEPTH));
  assign w_push      = i_alu_valid && o_alu_ready && !w_full && (i_alu_rd != '0);
  assign w_pop       = !i_ld_valid && !w_empty;
  assign w_alu_req   = '{rd: i_alu_rd, data: i_alu_data};
  assign w_ld_we     = i_ld_valid && (i_ld_rd != '0) && (i_ld_funct3 != 3'b111);

  wb_skid_fifo #(.DEPTH(ALU_DEPTH), .WIDTH($bits(wb_req_t))) u_alu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_alu_req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en <= 1'b0;
      r_reg   <= '0;
      r_data  <= '0;
    end else if (i_ld_valid) begin
      r_wr_en <= w_ld_we;
      if (w_ld_we) begin
        r_reg  <= i_ld_rd;
        r_data <= load_extend(i_ld_funct3, i_ld_offset, i_ld_raw);
      end
    end else if (w_pop) begin
      r_wr_en <= 1'b1;
      r_reg   <= w_head.rd;
      r_data  <= w_head.data;
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  // Issue is OR'd in after the return clear so a same-edge re-issue stays busy.
  assign w_set = i_ld_issue ? (NREGS_P'(1) << i_ld_issue_rd) : '0;
  assign w_clr = i_ld_valid ? (NREGS_P'(1) << i_ld_rd) : '0;

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS_P'(1);
  end

  assign o_wr_en      = r_wr_en;
  assign o_destn_reg  = r_reg;
  assign o_destn_data = r_data;
  assign o_busy_mask  = r_busy;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases then random traffic
// against a queue-based reference model.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3, ld_offset;
  logic [63:0] ld_raw;
  logic        wr_en;
  logic [4:0]  destn_reg;
  logic [63:0] destn_data;
  logic [31:0] busy_mask;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         alu_q[$];
  logic [31:0] m_busy = '0;

  writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .i_alu_valid   (alu_valid),
    .o_alu_ready   (alu_ready),
    .i_alu_rd      (alu_rd),
    .i_alu_data    (alu_data),
    .i_ld_issue    (ld_issue),
    .i_ld_issue_rd (ld_issue_rd),
    .i_ld_valid    (ld_valid),
    .i_ld_rd       (ld_rd),
    .i_ld_funct3   (ld_funct3),
    .i_ld_offset   (ld_offset),
    .i_ld_raw      (ld_raw),
    .o_wr_en       (wr_en),
    .o_destn_reg   (destn_reg),
    .o_destn_data  (destn_data),
    .o_busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  // Extension from first principles: size in bytes, aligned shift, mask, sign fill.
  function automatic logic [63:0] ref_ext(input logic [2:0] f3, input logic [2:0] off,
                                          input logic [63:0] raw);
    int nb, sh;
    logic [63:0] m, v;
    nb = 1 << f3[1:0];
    sh = (int'(off) / nb) * nb * 8;
    m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    v  = (raw >> sh) & m;
    if (!f3[2] && v[nb*8-1]) v = v | ~m;
    return v;
  endfunction

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", destn_reg, destn_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (destn_reg !== e.rd || destn_data !== e.d) begin
          errors++;
          $display("FAIL write: got rd=%0d data=%h, required rd=%0d data=%h",
                   destn_reg, destn_data, e.rd, e.d);
        end
      end
    end
  end

  // One cycle: check ready/busy, drive inputs, advance the model, clock.
  task automatic cyc(input bit rst, input bit av, input logic [4:0] ard, input logic [63:0] ad,
                     input bit iss, input logic [4:0] ird,
                     input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                     input logic [2:0] off, input logic [63:0] raw);
    bit m_rdy;
    m_rdy = !reset && (alu_q.size() < 2);
    checks++;
    if (alu_ready !== m_rdy) begin
      errors++;
      $display("FAIL alu_ready: got %b, required %b", alu_ready, m_rdy);
    end
    checks++;
    if (busy_mask !== m_busy) begin
      errors++;
      $display("FAIL busy_mask: got %h, required %h", busy_mask, m_busy);
    end
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue = iss; ld_issue_rd = ird; ld_valid = lv; ld_rd = lrd;
    ld_funct3 = f3; ld_offset = off; ld_raw = raw;
    m_rdy = !rst && (alu_q.size() < 2);
    if (rst) begin
      alu_q.delete();
      m_busy = '0;
    end else begin
      if (lv) begin
        if (lrd != 0 && f3 != 3'b111) exp_q.push_back('{rd: lrd, d: ref_ext(f3, off, raw)});
      end else if (alu_q.size() > 0) begin
        exp_q.push_back(alu_q.pop_front());
      end
      if (av && m_rdy && ard != 0) alu_q.push_back('{rd: ard, d: ad});
      if (lv)  m_busy[lrd] = 1'b0;
      if (iss) m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    cyc(0, 1, rd, d, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                    input logic [63:0] raw);
    cyc(0, 0, 0, 0, 0, 0, 1, rd, f3, off, raw);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0; ld_raw = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 64'h55, 1, 4, 0, 0, 0, 0, 0);

    // ALU single result
    alu(5, 64'h1234);
    idle(3);

    // Load extension cases
    ld(7, 3'b000, 3'd3, 64'h0000_0000_8000_0000);
    ld(7, 3'b100, 3'd3, 64'h0000_0000_8000_0000);
    ld(7, 3'b110, 3'd4, 64'h89AB_CDEF_0000_0000);
    ld(8, 3'b001, 3'd7, 64'h8765_4321_1234_5678);
    ld(8, 3'b010, 3'd5, 64'hF000_0001_0000_0000);
    ld(8, 3'b011, 3'd1, 64'hDEAD_BEEF_CAFE_F00D);
    ld(8, 3'b101, 3'd2, 64'h0000_0000_C001_0000);
    ld(3, 3'b111, 3'd0, 64'h1111_1111_1111_1111);
    idle(2);

    // Loads hold priority for 4 cycles while ALU offers 3 results
    cyc(0, 1, 11, 64'hA1, 0, 0, 1, 12, 3'b011, 0, 64'h1);
    cyc(0, 1, 13, 64'hA2, 0, 0, 1, 14, 3'b011, 0, 64'h2);
    cyc(0, 1, 15, 64'hA3, 0, 0, 1, 16, 3'b011, 0, 64'h3);
    cyc(0, 0, 0, 0, 0, 0, 1, 17, 3'b011, 0, 64'h4);
    idle(4);

    // Scoreboard: set, same-edge clear+set, clear
    cyc(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 9, 1, 9, 3'b011, 0, 64'h99);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 3'b011, 0, 64'h98);
    idle(1);

    // x0 destinations never write or mark busy
    alu(0, 64'hBAD);
    ld(0, 3'b011, 0, 64'hBAD);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Reset mid-operation with two queued ALU results and a busy load
    cyc(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    cyc(0, 1, 10, 64'hC1, 0, 0, 1, 20, 3'b011, 0, 64'h5);
    cyc(0, 1, 10, 64'hC2, 0, 0, 1, 21, 3'b011, 0, 64'h6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 3'($urandom),
          3'($urandom), {$urandom, $urandom});
    end
    idle(6);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected writes never appeared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
